// File: rtl/flash_pkg.sv
// Shared opcodes, frame lengths and FSM state type for the SPI flash command engine.
package flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam logic [6:0] FRAME_LEN_8  = 7'd8;
    localparam logic [6:0] FRAME_LEN_16 = 7'd16;
    localparam logic [6:0] FRAME_LEN_64 = 7'd64;

    typedef enum logic [2:0] {
        StIdle,
        StRdFrame,
        StWrenFrame,
        StPpFrame,
        StPollFrame,
        StGap
    } state_e;

    // The flash streams bytes in address order; the bus word is little-endian.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_spi_engine_if.sv
// Request/response handshake between the flash controller and the SPI command engine.
interface flash_spi_engine_if;

    logic        flash_enable;
    logic        read_enable;
    logic        write_enable;
    logic [23:0] address;
    logic [31:0] data_in;
    logic        ready;
    logic [31:0] data_out;
    logic        error;

    modport master (
        output flash_enable, read_enable, write_enable, address, data_in,
        input  ready, data_out, error
    );

    modport slave (
        input  flash_enable, read_enable, write_enable, address, data_in,
        output ready, data_out, error
    );

endinterface

// File: rtl/flash_spi_shifter.sv
// Mode-0 SPI bit engine: shifts out up to 64 bits MSB first and collects MISO bits.
module flash_spi_shifter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [6:0]  bit_count,
    input  logic [63:0] tx_word,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [31:0] rx_word
);

    localparam int unsigned DivW = $clog2(2 * CLK_DIV);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(2 * CLK_DIV - 1);

    logic            active_q;
    logic [DivW-1:0] div_q;
    logic [6:0]      bits_q;
    logic [63:0]     sr_q;
    logic [31:0]     rx_q;
    logic            sample;
    logic            bit_end;

    assign sample  = active_q && (div_q == DivHalf);
    assign bit_end = active_q && (div_q == DivLast);
    assign done    = bit_end && (bits_q == 7'd1);
    // SCK low for the first half of each bit, high for the second.
    assign sck     = active_q && (div_q >= DivHalf);
    assign mosi    = active_q && sr_q[63];
    assign rx_word = rx_q;

    // Divider, bit counter and shift registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bits_q   <= '0;
            sr_q     <= '0;
            rx_q     <= '0;
        end else if (load) begin
            active_q <= 1'b1;
            div_q    <= '0;
            bits_q   <= bit_count;
            sr_q     <= tx_word;
        end else if (active_q) begin
            if (sample) begin
                rx_q <= {rx_q[30:0], miso};
            end
            if (bit_end) begin
                div_q  <= '0;
                sr_q   <= {sr_q[62:0], 1'b0};
                bits_q <= bits_q - 1'b1;
                if (bits_q == 7'd1) begin
                    active_q <= 1'b0;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_spi_engine.sv
// SPI flash command engine: one-word READ, or WREN + PAGE PROGRAM + RDSR busy polling.
module flash_spi_engine
    import flash_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_IDLE  = 4,
    parameter int unsigned POLL_MAX = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    flash_spi_engine_if.slave        bus,
    input  logic                     flashMiso,
    output logic                     flashClk,
    output logic                     flashMosi,
    output logic                     flashCs
);

    localparam int unsigned GapW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(CS_IDLE - 1);

    state_e          state_q, state_d;
    state_e          after_gap_q, after_gap_d;
    logic [23:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_out_q, data_out_d;
    logic            error_q, error_d;
    logic [31:0]     poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

    logic            load;
    logic [6:0]      bit_count;
    logic [63:0]     tx_word;
    logic            frame_done;
    logic [31:0]     rx_word;

    flash_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .bit_count (bit_count),
        .tx_word   (tx_word),
        .miso      (flashMiso),
        .sck       (flashClk),
        .mosi      (flashMosi),
        .done      (frame_done),
        .rx_word   (rx_word)
    );

    assign flashCs      = (state_q == StIdle) || (state_q == StGap);
    assign bus.ready    = (state_q == StIdle);
    assign bus.data_out = data_out_q;
    assign bus.error    = error_q;

    // State and command registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            after_gap_q <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_out_q  <= '0;
            error_q     <= 1'b0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_out_q  <= data_out_d;
            error_q     <= error_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    // Next-state logic and frame launch; each frame is followed by a CS-high gap.
    always_comb begin
        state_d     = state_q;
        after_gap_d = after_gap_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_out_d  = data_out_q;
        error_d     = error_q;
        poll_cnt_d  = poll_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        load        = 1'b0;
        bit_count   = FRAME_LEN_8;
        tx_word     = '0;

        case (state_q)
            StIdle: begin
                if (bus.flash_enable && (bus.read_enable || bus.write_enable)) begin
                    addr_d     = bus.address;
                    wdata_d    = bus.data_in;
                    error_d    = 1'b0;
                    poll_cnt_d = '0;
                    load       = 1'b1;
                    // Read takes priority when both requests are present.
                    if (bus.read_enable) begin
                        state_d   = StRdFrame;
                        bit_count = FRAME_LEN_64;
                        tx_word   = {CMD_READ, bus.address, 32'h0};
                    end else begin
                        state_d   = StWrenFrame;
                        bit_count = FRAME_LEN_8;
                        tx_word   = {CMD_WREN, 56'h0};
                    end
                end
            end
            StRdFrame: begin
                if (frame_done) begin
                    data_out_d  = byte_swap(rx_word);
                    state_d     = StGap;
                    after_gap_d = StIdle;
                    gap_cnt_d   = '0;
                end
            end
            StWrenFrame: begin
                if (frame_done) begin
                    state_d     = StGap;
                    after_gap_d = StPpFrame;
                    gap_cnt_d   = '0;
                end
            end
            StPpFrame: begin
                if (frame_done) begin
                    state_d     = StGap;
                    after_gap_d = StPollFrame;
                    gap_cnt_d   = '0;
                end
            end
            StPollFrame: begin
                if (frame_done) begin
                    state_d    = StGap;
                    gap_cnt_d  = '0;
                    poll_cnt_d = poll_cnt_q + 32'd1;
                    // Last received bit is status[0], the write-in-progress flag.
                    if (!rx_word[0]) begin
                        after_gap_d = StIdle;
                    end else if ((poll_cnt_q + 32'd1) >= POLL_MAX) begin
                        error_d     = 1'b1;
                        after_gap_d = StIdle;
                    end else begin
                        after_gap_d = StPollFrame;
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    state_d   = after_gap_q;
                    if (after_gap_q == StPpFrame) begin
                        load      = 1'b1;
                        bit_count = FRAME_LEN_64;
                        tx_word   = {CMD_PP, addr_q, byte_swap(wdata_q)};
                    end else if (after_gap_q == StPollFrame) begin
                        load      = 1'b1;
                        bit_count = FRAME_LEN_16;
                        tx_word   = {CMD_RDSR, 56'h0};
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
